arith_step_sequencer: RTL

Sequencer for the timing control tank and shifting unit during multiply (V/N) and shift (R/L) orders. It accepts an order from main control and launches the tank with a zero_d0 pulse aligned to digit 0. It holds the c5/c6 enables that keep the tank recirculating, counts dy pulses until the required number of steps is done, then drops the enables and reports completion. A watchdog aborts the order if the tank stops producing dy.

---
 rtl/edsac_ctrl_pkg.sv | 25 ++
 rtl/arith_step_sequencer_if.sv | 30 +++
 rtl/arith_step_sequencer_lsb_index.sv | 18 +
 rtl/arith_step_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/edsac_ctrl_pkg.sv
// Shared types and constants for the arithmetic-step sequencer that drives the
// timing control tank during multiply (V/N) and shift (R/L) orders.
package edsac_ctrl_pkg;

  localparam int MC_LEN           = 36;
  localparam int MULT_STEPS_SHORT = 17;
  localparam int MULT_STEPS_LONG  = 35;
  localparam int ADDR_W           = 11;
  localparam int TIMEOUT          = 80;
  localparam int STEP_W           = 6;
  localparam int WD_W             = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DONE,
    ABORT
  } state_t;

  function automatic logic [STEP_W-1:0] mult_steps(input logic long_op);
    return long_op ? STEP_W'(MULT_STEPS_LONG) : STEP_W'(MULT_STEPS_SHORT);
  endfunction

endpackage

// File: rtl/arith_step_sequencer_if.sv
// Order handshake from main control plus the launch/enable/step lines shared
// with the timing control tank.
interface arith_step_sequencer_if;
  import edsac_ctrl_pkg::*;

  logic              d0;
  logic              start;
  logic              is_mult;
  logic              long_op;
  logic [ADDR_W-1:0] addr;
  logic              dy;
  logic              zero_d0;
  logic              c5;
  logic              c6;
  logic              busy;
  logic              done;
  logic              err;
  logic [STEP_W-1:0] steps_left;

  modport master (
    output d0, start, is_mult, long_op, addr, dy,
    input  zero_d0, c5, c6, busy, done, err, steps_left
  );

  modport slave (
    input  d0, start, is_mult, long_op, addr, dy,
    output zero_d0, c5, c6, busy, done, err, steps_left
  );

endinterface

// File: rtl/arith_step_sequencer_lsb_index.sv
// Shift-count encoder: index of the lowest set bit of the order address plus 1,
// or 0 when the field is empty.
module arith_step_sequencer_lsb_index
  import edsac_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [STEP_W-1:0] idx_o
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      if (addr_i[i]) idx_o = STEP_W'(i + 1);
    end
  end

endmodule

// File: rtl/arith_step_sequencer.sv
// Launches the timing tank on digit 0, holds c5/c6 while counting dy steps,
// and reports completion or a watchdog abort.
//
//   state | meaning
//   IDLE  | no order; accepts start
//   ARM   | order latched, waiting for d0 to launch the tank
//   RUN   | c5/c6 held, counting dy, watchdog running
//   DONE  | one-clock completion pulse
//   ABORT | one-clock error pulse, enables dropped
module arith_step_sequencer
  import edsac_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  arith_step_sequencer_if.slave bus
);

  // The launch clock counts as the first watchdog clock, so err lands exactly
  // TIMEOUT clocks after zero_d0 or the last dy.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              is_mult_q, is_mult_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              empty_err_q, empty_err_d;
  logic [STEP_W-1:0] shift_n;
  logic              launch;
  logic              enable;

  arith_step_sequencer_lsb_index u_lsb_index (
    .addr_i (bus.addr),
    .idx_o  (shift_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_mult_q    <= 1'b0;
      steps_left_q <= '0;
      wd_q         <= '0;
      empty_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_mult_q    <= is_mult_d;
      steps_left_q <= steps_left_d;
      wd_q         <= wd_d;
      empty_err_q  <= empty_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_mult_d    = is_mult_q;
    steps_left_d = steps_left_q;
    wd_d         = wd_q;
    empty_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.is_mult) begin
            is_mult_d    = 1'b1;
            steps_left_d = mult_steps(bus.long_op);
            state_d      = ARM;
          end else if (shift_n != '0) begin
            is_mult_d    = 1'b0;
            steps_left_d = shift_n;
            state_d      = ARM;
          end else begin
            empty_err_d  = 1'b1;
          end
        end
      end

      ARM: begin
        if (bus.d0) begin
          wd_d    = WD_LOAD;
          state_d = RUN;
        end
      end

      RUN: begin
        // A dy in the expiry clock still counts as a step.
        if (bus.dy) begin
          steps_left_d = steps_left_q - STEP_W'(1);
          wd_d         = WD_LOAD;
          if (steps_left_q == STEP_W'(1)) state_d = DONE;
        end else if (wd_q <= WD_W'(1)) begin
          wd_d         = '0;
          steps_left_d = '0;
          state_d      = ABORT;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end

      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign launch = (state_q == ARM) && bus.d0;
  assign enable = launch || (state_q == RUN);

  assign bus.zero_d0    = launch;
  assign bus.c5         = enable && is_mult_q;
  assign bus.c6         = enable && !is_mult_q;
  assign bus.busy       = (state_q == ARM) || (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.err        = (state_q == ABORT) || empty_err_q;
  assign bus.steps_left = steps_left_q;

endmodule
